// File: rtl/ads1278_frame_rx.sv
// ADS1278 SPI/TDM fixed-position frame reader: generates SCLK after each DRDY
// falling edge and delivers the channel words as one-cycle sample strobes.
module ads1278_frame_rx #(
    parameter int unsigned SCLK_DIV = 2,
    parameter int unsigned NUM_CH   = 8,
    parameter int unsigned SAMPLE_W = 24
) (
    input  logic                clkin,
    input  logic                reset,
    input  logic                adc_clk_lock,
    input  logic                drdy_n,
    input  logic                dout,
    output logic                sclk,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic [2:0]          sample_ch,
    output logic                sample_valid,
    output logic                frame_done,
    output logic                overrun,
    output logic                busy
);

    localparam int unsigned DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int unsigned WB_W  = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_HI = 2'd1,
        SHIFT_LO = 2'd2
    } state_t;

    state_t              state;
    state_t              state_d;

    logic [1:0]          lock_sync;
    logic [1:0]          drdy_sync;
    logic [1:0]          dout_sync;
    logic                drdy_q;
    logic                lock_s;
    logic                drdy_s;
    logic                dout_s;
    logic                drdy_fall_c;

    logic [DIV_W-1:0]    div_cnt;
    logic [WB_W-1:0]     word_bit;
    logic [CH_W-1:0]     ch_cnt;
    logic [SAMPLE_W-1:0] shreg;

    logic                div_last_c;
    logic                word_end_c;
    logic                last_ch_c;
    logic                div_clr_c;
    logic                cnt_clr_c;
    logic                shift_c;
    logic                bit_adv_c;
    logic                strobe_c;
    logic                overrun_c;

    assign lock_s = lock_sync[1];
    assign drdy_s = drdy_sync[1];
    assign dout_s = dout_sync[1];

    assign drdy_fall_c = ~drdy_s & drdy_q;
    assign div_last_c  = (div_cnt == DIV_W'(SCLK_DIV - 1));
    assign word_end_c  = (word_bit == WB_W'(SAMPLE_W - 1));
    assign last_ch_c   = (ch_cnt == CH_W'(NUM_CH - 1));

    // Two-flop synchronizers; DRDY idles high so its chain clears to 1
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            lock_sync <= 2'b00;
            drdy_sync <= 2'b11;
            dout_sync <= 2'b00;
            drdy_q    <= 1'b1;
        end else begin
            lock_sync <= {lock_sync[0], adc_clk_lock};
            drdy_sync <= {drdy_sync[0], drdy_n};
            dout_sync <= {dout_sync[0], dout};
            drdy_q    <= drdy_s;
        end
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Lock loss outranks a new DRDY; a DRDY while shifting restarts the frame
    always_comb begin
        state_d   = state;
        cnt_clr_c = 1'b0;
        shift_c   = 1'b0;
        bit_adv_c = 1'b0;
        strobe_c  = 1'b0;
        overrun_c = 1'b0;
        case (state)
            IDLE: begin
                if (drdy_fall_c && lock_s) begin
                    state_d   = SHIFT_HI;
                    cnt_clr_c = 1'b1;
                end
            end
            SHIFT_HI: begin
                if (!lock_s) begin
                    state_d = IDLE;
                end else if (drdy_fall_c) begin
                    overrun_c = 1'b1;
                    cnt_clr_c = 1'b1;
                end else if (div_last_c) begin
                    shift_c  = 1'b1;
                    strobe_c = word_end_c;
                    state_d  = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (!lock_s) begin
                    state_d = IDLE;
                end else if (drdy_fall_c) begin
                    overrun_c = 1'b1;
                    cnt_clr_c = 1'b1;
                    state_d   = SHIFT_HI;
                end else if (div_last_c) begin
                    if (word_end_c && last_ch_c) begin
                        state_d = IDLE;
                    end else begin
                        bit_adv_c = 1'b1;
                        state_d   = SHIFT_HI;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign div_clr_c = (state == IDLE) || (state_d != state) || cnt_clr_c;

    // SCLK phase divider and bit/channel position within the frame
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            div_cnt  <= '0;
            word_bit <= '0;
            ch_cnt   <= '0;
            shreg    <= '0;
        end else begin
            div_cnt <= div_clr_c ? '0 : div_cnt + DIV_W'(1);
            if (cnt_clr_c) begin
                word_bit <= '0;
                ch_cnt   <= '0;
                shreg    <= '0;
            end else begin
                if (shift_c) begin
                    shreg <= {shreg[SAMPLE_W-2:0], dout_s};
                end
                if (bit_adv_c) begin
                    if (word_end_c) begin
                        word_bit <= '0;
                        ch_cnt   <= ch_cnt + CH_W'(1);
                    end else begin
                        word_bit <= word_bit + WB_W'(1);
                    end
                end
            end
        end
    end

    // Registered outputs, driven from the next state so SCLK rises right after the DRDY edge
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            sclk         <= 1'b0;
            busy         <= 1'b0;
            sample_data  <= '0;
            sample_ch    <= 3'd0;
            sample_valid <= 1'b0;
            frame_done   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sclk         <= (state_d == SHIFT_HI);
            busy         <= (state_d != IDLE);
            sample_valid <= strobe_c;
            frame_done   <= strobe_c && last_ch_c;
            overrun      <= overrun_c;
            if (strobe_c) begin
                sample_data <= {shreg[SAMPLE_W-2:0], dout_s};
                sample_ch   <= 3'(ch_cnt);
            end
        end
    end

endmodule

// File: tb/tb_ads1278_frame_rx.sv
// Directed bench for ads1278_frame_rx: default instance plus a SCLK_DIV=5, NUM_CH=2 instance,
// each fed by a behavioural ADC that shifts DOUT on SCLK falling edges.
module tb_ads1278_frame_rx;

    localparam logic [23:0] WORDS_A [8] = '{24'h000001, 24'h7FFFFF, 24'h800000, 24'hFFFFFF,
                                            24'hA5A5A5, 24'h5A5A5A, 24'h123456, 24'hFEDCBA};
    localparam logic [23:0] WORDS_B [8] = '{24'h13579B, 24'h2468AC, 24'hDEADBE, 24'h0F0F0F,
                                            24'hF0F0F0, 24'h000000, 24'hFFFFFE, 24'h800001};

    logic        clkin = 1'b0;
    logic        reset = 1'b1;
    logic        adc_clk_lock = 1'b0;
    logic        drdy_n = 1'b1;
    logic        dout = 1'b0;
    logic        drdy2_n = 1'b1;
    logic        dout2 = 1'b0;

    logic        sclk, sample_valid, frame_done, overrun, busy;
    logic [23:0] sample_data;
    logic [2:0]  sample_ch;
    logic        sclk2, sample_valid2, frame_done2, overrun2, busy2;
    logic [23:0] sample_data2;
    logic [2:0]  sample_ch2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    ads1278_frame_rx dut (
        .clkin(clkin), .reset(reset), .adc_clk_lock(adc_clk_lock), .drdy_n(drdy_n), .dout(dout),
        .sclk(sclk), .sample_data(sample_data), .sample_ch(sample_ch), .sample_valid(sample_valid),
        .frame_done(frame_done), .overrun(overrun), .busy(busy)
    );

    ads1278_frame_rx #(.SCLK_DIV(5), .NUM_CH(2), .SAMPLE_W(24)) dut2 (
        .clkin(clkin), .reset(reset), .adc_clk_lock(adc_clk_lock), .drdy_n(drdy2_n), .dout(dout2),
        .sclk(sclk2), .sample_data(sample_data2), .sample_ch(sample_ch2), .sample_valid(sample_valid2),
        .frame_done(frame_done2), .overrun(overrun2), .busy(busy2)
    );

    always #5 clkin = ~clkin;
    always @(posedge clkin) cyc = cyc + 1;

    // ADC models: DRDY fall presents the MSB of word 0, each SCLK fall moves to the next bit
    logic [23:0] adc_words [8];
    logic [23:0] adc_words2 [2];
    int          bp = 192;
    int          bp2 = 48;
    logic        drdy_mq = 1'b1, sclk_mq = 1'b0, drdy2_mq = 1'b1, sclk2_mq = 1'b0;
    logic [23:0] mw, mw2;

    always @(negedge clkin) begin
        if (drdy_mq && !drdy_n) bp = 0;
        else if (sclk_mq && !sclk) bp = bp + 1;
        drdy_mq = drdy_n;
        sclk_mq = sclk;
        if (bp < 192) begin
            mw = adc_words[3'(bp / 24)];
            dout = mw[5'(23 - (bp % 24))];
        end else dout = 1'b0;

        if (drdy2_mq && !drdy2_n) bp2 = 0;
        else if (sclk2_mq && !sclk2) bp2 = bp2 + 1;
        drdy2_mq = drdy2_n;
        sclk2_mq = sclk2;
        if (bp2 < 48) begin
            mw2 = adc_words2[1'(bp2 / 24)];
            dout2 = mw2[5'(23 - (bp2 % 24))];
        end else dout2 = 1'b0;
    end

    // Output monitor, sampled mid-cycle
    int          n = 0, fd_cnt = 0, ov_cnt = 0, rise_cnt = 0, busy_cnt = 0;
    logic [2:0]  log_ch [128];
    logic [23:0] log_data [128];
    int          log_cyc [128];
    logic        log_fd [128];
    logic        sclk_q = 1'b0, busy_q = 1'b0;
    int          low_run = 0, ngap = 0;
    int          gaps [64];
    int          n2 = 0, fd2_cnt = 0, rise2_cnt = 0, busy2_cnt = 0, last_rise2 = 0, prev_rise2 = 0;
    logic [2:0]  log2_ch [8];
    logic [23:0] log2_data [8];
    int          log2_cyc [8];
    logic        log2_fd [8];
    logic        sclk2_q = 1'b0;

    always @(negedge clkin) begin
        if (sample_valid && n < 128) begin
            log_ch[n] = sample_ch; log_data[n] = sample_data; log_cyc[n] = cyc; log_fd[n] = frame_done;
            n = n + 1;
        end
        if (frame_done) fd_cnt = fd_cnt + 1;
        if (overrun) ov_cnt = ov_cnt + 1;
        if (sclk && !sclk_q) rise_cnt = rise_cnt + 1;
        sclk_q = sclk;
        if (busy) busy_cnt = busy_cnt + 1;
        if (busy && !busy_q && ngap < 64) begin gaps[ngap] = low_run; ngap = ngap + 1; end
        low_run = busy ? 0 : low_run + 1;
        busy_q = busy;

        if (sample_valid2 && n2 < 8) begin
            log2_ch[n2] = sample_ch2; log2_data[n2] = sample_data2; log2_cyc[n2] = cyc; log2_fd[n2] = frame_done2;
            n2 = n2 + 1;
        end
        if (frame_done2) fd2_cnt = fd2_cnt + 1;
        if (sclk2 && !sclk2_q) begin rise2_cnt = rise2_cnt + 1; prev_rise2 = last_rise2; last_rise2 = cyc; end
        sclk2_q = sclk2;
        if (busy2) busy2_cnt = busy2_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Default instance: word k of a frame whose DRDY edge is cycle e strobes at e + (24k+23)*4 + 3
    task automatic check_word(input int idx, input int k, input int e, input logic [23:0] w);
        check($sformatf("ch_idx%0d", idx), 64'(log_ch[idx]), 64'(k));
        check($sformatf("data_idx%0d", idx), 64'(log_data[idx]), 64'(w));
        check($sformatf("cyc_idx%0d", idx), 64'(log_cyc[idx]), 64'(e + ((k + 1) * 24 - 1) * 4 + 3));
        check($sformatf("fd_idx%0d", idx), 64'(log_fd[idx]), 64'(k == 7));
    endtask

    task automatic start_frame(output int e);
        @(posedge clkin); #1;
        drdy_n = 1'b0;
        e = cyc + 2;
        repeat (8) @(posedge clkin);
        #1 drdy_n = 1'b1;
    endtask

    task automatic wait_strobes(input int target, input int budget, input string tag);
        int t = 0;
        while (n < target && t < budget) begin
            @(posedge clkin); #1;
            t = t + 1;
        end
        check({tag, "_wait"}, 64'(n >= target), 64'd1);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clkin); #1;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, observed cycle %0d, required under 90000", cyc);
        $fatal(1);
    end

    int e, e1, e2, n0, fd0, ov0, r0, b0, g0, t, L, rl;
    int eb [3];
    logic prev;

    initial begin
        adc_words  = WORDS_A;
        adc_words2 = '{24'hC00003, 24'h00FF00};
        adc_clk_lock = 1'b1;

        // Reset values
        repeat (3) @(posedge clkin);
        #1;
        check("rst_sclk", 64'(sclk), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(sample_valid), 64'd0);
        check("rst_data_ch", 64'({sample_data, sample_ch}), 64'd0);
        check("rst_fd_ov", 64'({frame_done, overrun}), 64'd0);
        check("rst_dut2", 64'({sclk2, busy2, sample_valid2, frame_done2, overrun2, sample_data2, sample_ch2}), 64'd0);
        reset = 1'b0;
        repeat (10) @(posedge clkin);
        #1;

        // Nominal frame
        n0 = n; fd0 = fd_cnt; ov0 = ov_cnt; r0 = rise_cnt; b0 = busy_cnt;
        start_frame(e);
        wait_strobes(n0 + 8, 1000, "nom");
        repeat (20) @(posedge clkin);
        #1;
        for (int k = 0; k < 8; k++) check_word(n0 + k, k, e, WORDS_A[k]);
        check("nom_count", 64'(n - n0), 64'd8);
        check("nom_fd", 64'(fd_cnt - fd0), 64'd1);
        check("nom_ov", 64'(ov_cnt - ov0), 64'd0);
        check("nom_rises", 64'(rise_cnt - r0), 64'd192);
        check("nom_busy", 64'(busy_cnt - b0), 64'd768);

        // SCLK_DIV=5, NUM_CH=2 instance
        r0 = rise2_cnt; b0 = busy2_cnt; fd0 = fd2_cnt;
        @(posedge clkin); #1;
        drdy2_n = 1'b0;
        e = cyc + 2;
        repeat (8) @(posedge clkin);
        #1 drdy2_n = 1'b1;
        t = 0;
        while (n2 < 2 && t < 1000) begin @(posedge clkin); #1; t = t + 1; end
        check("d2_wait", 64'(n2 >= 2), 64'd1);
        repeat (20) @(posedge clkin);
        #1;
        check("d2_ch0", 64'({log2_ch[0], log2_data[0]}), 64'({3'd0, 24'hC00003}));
        check("d2_ch1", 64'({log2_ch[1], log2_data[1]}), 64'({3'd1, 24'h00FF00}));
        check("d2_cyc0", 64'(log2_cyc[0]), 64'(e + 236));
        check("d2_cyc1", 64'(log2_cyc[1]), 64'(e + 476));
        check("d2_fd", 64'({log2_fd[0], log2_fd[1]}), 64'b01);
        check("d2_fd_cnt", 64'(fd2_cnt - fd0), 64'd1);
        check("d2_rises", 64'(rise2_cnt - r0), 64'd48);
        check("d2_period", 64'(last_rise2 - prev_rise2), 64'd10);
        check("d2_busy", 64'(busy2_cnt - b0), 64'd480);

        // Overrun after ch2
        n0 = n; fd0 = fd_cnt; ov0 = ov_cnt;
        adc_words = WORDS_A;
        start_frame(e1);
        wait_strobes(n0 + 3, 1000, "ovr_pre");
        prev = sclk;
        t = 0;
        while (t < 20) begin
            @(posedge clkin); #1;
            t = t + 1;
            if (prev && !sclk) break;
            prev = sclk;
        end
        drdy_n = 1'b0;
        adc_words = WORDS_B;
        e2 = cyc + 2;
        repeat (8) @(posedge clkin);
        #1 drdy_n = 1'b1;
        wait_strobes(n0 + 11, 1000, "ovr_post");
        repeat (20) @(posedge clkin);
        #1;
        for (int k = 0; k < 3; k++) check_word(n0 + k, k, e1, WORDS_A[k]);
        for (int k = 0; k < 8; k++) check_word(n0 + 3 + k, k, e2, WORDS_B[k]);
        check("ovr_count", 64'(n - n0), 64'd11);
        check("ovr_pulses", 64'(ov_cnt - ov0), 64'd1);
        check("ovr_fd", 64'(fd_cnt - fd0), 64'd1);

        // DRDY without lock is ignored
        adc_clk_lock = 1'b0;
        repeat (5) @(posedge clkin);
        n0 = n; r0 = rise_cnt; b0 = busy_cnt;
        start_frame(e);
        repeat (100) @(posedge clkin);
        #1;
        check("nolock_rises", 64'(rise_cnt - r0), 64'd0);
        check("nolock_busy", 64'(busy_cnt - b0), 64'd0);
        check("nolock_strobes", 64'(n - n0), 64'd0);

        // Lock drop after ch4
        adc_clk_lock = 1'b1;
        repeat (5) @(posedge clkin);
        n0 = n; fd0 = fd_cnt; ov0 = ov_cnt;
        adc_words = WORDS_A;
        start_frame(e);
        wait_strobes(n0 + 5, 1000, "lock");
        adc_clk_lock = 1'b0;
        L = cyc;
        repeat (4) @(posedge clkin);
        #1;
        check("lockdrop_sclk_busy", 64'({sclk, busy}), 64'd0);
        rl = rise_cnt;
        repeat (300) @(posedge clkin);
        #1;
        for (int k = 0; k < 5; k++) check_word(n0 + k, k, e, WORDS_A[k]);
        check("lockdrop_strobes", 64'(n - n0), 64'd5);
        check("lockdrop_fd", 64'(fd_cnt - fd0), 64'd0);
        check("lockdrop_ov", 64'(ov_cnt - ov0), 64'd0);
        check("lockdrop_no_sclk", 64'(rise_cnt - rl), 64'd0);
        adc_clk_lock = 1'b1;
        repeat (5) @(posedge clkin);

        // Asynchronous reset during ch3
        n0 = n;
        adc_words = WORDS_B;
        start_frame(e);
        wait_strobes(n0 + 3, 1000, "rst_mid");
        repeat (10) @(posedge clkin);
        #1;
        check("rstmid_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("rstmid_outputs", 64'({sclk, busy, sample_valid, frame_done, overrun, sample_data, sample_ch}), 64'd0);
        repeat (5) @(posedge clkin);
        #1 reset = 1'b0;
        n0 = n; b0 = busy_cnt;
        repeat (50) @(posedge clkin);
        #1;
        check("rstmid_quiet_strobes", 64'(n - n0), 64'd0);
        check("rstmid_quiet_busy", 64'(busy_cnt - b0), 64'd0);
        fd0 = fd_cnt;
        start_frame(e);
        wait_strobes(n0 + 8, 1000, "rst_new");
        repeat (20) @(posedge clkin);
        #1;
        for (int k = 0; k < 8; k++) check_word(n0 + k, k, e, WORDS_B[k]);
        check("rstnew_fd", 64'(fd_cnt - fd0), 64'd1);

        // Back-to-back frames, DRDY period 800
        n0 = n; fd0 = fd_cnt; ov0 = ov_cnt; g0 = ngap;
        adc_words = WORDS_A;
        start_frame(eb[0]);
        wait_until(eb[0] - 2 + 799);
        start_frame(eb[1]);
        wait_until(eb[1] - 2 + 799);
        start_frame(eb[2]);
        wait_strobes(n0 + 24, 1000, "b2b");
        repeat (20) @(posedge clkin);
        #1;
        check("b2b_spacing", 64'(eb[2] - eb[0]), 64'd1600);
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < 8; k++) check_word(n0 + f * 8 + k, k, eb[f], WORDS_A[k]);
        check("b2b_count", 64'(n - n0), 64'd24);
        check("b2b_fd", 64'(fd_cnt - fd0), 64'd3);
        check("b2b_ov", 64'(ov_cnt - ov0), 64'd0);
        check("b2b_busy_rises", 64'(ngap - g0), 64'd3);
        check("b2b_gap1", 64'(gaps[g0 + 1]), 64'd32);
        check("b2b_gap2", 64'(gaps[g0 + 2]), 64'd32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
